// File: rtl/led_pio_pkg.sv
// Shared register map for the LED PIO/PWM block: Avalon register indices
// and the bit positions inside the STATUS register.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_SET        = 3'd1;
    localparam logic [2:0] ADDR_CLEAR      = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE     = 3'd3;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd4;
    localparam logic [2:0] ADDR_BLINK_HALF = 3'd5;
    localparam logic [2:0] ADDR_DUTY       = 3'd6;
    localparam logic [2:0] ADDR_STATUS     = 3'd7;

    localparam int STATUS_BLINK_BIT = 0;
    localparam int STATUS_PWM_BIT   = 1;

endpackage

// File: rtl/led_blink_timer.sv
// Blink timebase: counts up to the programmed half-period, then wraps and
// flips the blink phase. A restart pulse re-aligns the blink to the "on"
// phase so a new half-period always starts from a clean boundary.
module led_blink_timer #(
    parameter int BLINK_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLINK_W-1:0] half,
    input  logic               restart,
    output logic               phase
);

    logic [BLINK_W-1:0] blink_cnt;

    // Half-period counter and phase flip, with restart taking priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (restart) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == half) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM LED output port with atomic set/clear/toggle, per-bit blink
// masking and a global PWM dimmer. Reads are combinational, zero wait.
module led_pio_pwm #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          BLINK_W     = 24,
    parameter int          PWM_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    import led_pio_pkg::*;

    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   blink_mask;
    logic [BLINK_W-1:0] blink_half;
    logic [PWM_W-1:0]   duty;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               blink_phase;
    logic               pwm_on;
    logic               wr_en;
    logic               blink_restart;
    logic [WIDTH-1:0]   wd;
    logic [31:0]        status;
    logic               unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign blink_restart    = wr_en && (address == ADDR_BLINK_HALF);
    assign unused_writedata = ^writedata;

    // Full-scale duty is treated as always on so DUTY=all-ones is 100%
    assign pwm_on = (duty == '1) || (pwm_cnt < duty);

    led_blink_timer #(
        .BLINK_W(BLINK_W)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .half   (blink_half),
        .restart(blink_restart),
        .phase  (blink_phase)
    );

    // Register file writes; SET/CLEAR/TOGGLE are read-modify-write on DATA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg   <= RESET_VALUE[WIDTH-1:0];
            blink_mask <= '0;
            blink_half <= '0;
            duty       <= '1;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:       data_reg   <= wd;
                ADDR_SET:        data_reg   <= data_reg | wd;
                ADDR_CLEAR:      data_reg   <= data_reg & ~wd;
                ADDR_TOGGLE:     data_reg   <= data_reg ^ wd;
                ADDR_BLINK_MASK: blink_mask <= wd;
                ADDR_BLINK_HALF: blink_half <= writedata[BLINK_W-1:0];
                ADDR_DUTY:       duty       <= writedata[PWM_W-1:0];
                default:         data_reg   <= data_reg;
            endcase
        end
    end

    // Free-running PWM ramp, wraps naturally at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Registered LED drive: masked bits follow the blink phase, all bits gated by PWM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            out_port <= data_reg & (~blink_mask | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
        end
    end

    // STATUS image assembled from the live timer state
    always_comb begin
        status                   = '0;
        status[STATUS_BLINK_BIT] = blink_phase;
        status[STATUS_PWM_BIT]   = pwm_on;
    end

    // Combinational read mux; strobe-style registers read back as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = 32'(data_reg);
            ADDR_BLINK_MASK: readdata = 32'(blink_mask);
            ADDR_BLINK_HALF: readdata = 32'(blink_half);
            ADDR_DUTY:       readdata = 32'(duty);
            ADDR_STATUS:     readdata = status;
            default:         readdata = '0;
        endcase
    end

endmodule
